// File: rtl/gr8ram_pkg.sv
// Shared types and bus-phase constants for the GR8RAM DRAM scheduler.
package gr8ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REF_CAS,
    REF_CASRAS,
    REF_RAS,
    CPU_ROW,
    CPU_COL,
    CPU_HOLD
  } state_e;

  localparam logic [2:0] PH_SYNC   = 3'd1;
  localparam logic [2:0] PH_DECIDE = 3'd4;

endpackage

// File: rtl/ref_debt_ctr.sv
// Refresh interval timer plus saturating refresh-debt counter with sticky overflow flag.
module ref_debt_ctr #(
  parameter int REF_INTERVAL = 13,
  parameter int DEBT_MAX     = 4,
  parameter int DEBT_W       = 3
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              sync_edge,
  input  logic              ref_start,
  output logic [DEBT_W-1:0] debt,
  output logic              ref_lost
);

  localparam int IW = $clog2(REF_INTERVAL);

  logic [IW-1:0]     ivl_q, ivl_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              lost_q, lost_d;
  logic              credit;

  always_comb begin
    ivl_d  = ivl_q;
    credit = 1'b0;
    if (sync_edge) begin
      if (ivl_q == IW'(REF_INTERVAL - 1)) begin
        ivl_d  = '0;
        credit = 1'b1;
      end else begin
        ivl_d = ivl_q + 1'b1;
      end
    end

    debt_d = debt_q;
    lost_d = lost_q;
    // A credit and a refresh start on the same edge cancel out.
    if (credit && !ref_start) begin
      if (debt_q == DEBT_W'(DEBT_MAX)) lost_d = 1'b1;
      else                             debt_d = debt_q + 1'b1;
    end else if (ref_start && !credit) begin
      debt_d = debt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ivl_q  <= '0;
      debt_q <= '0;
      lost_q <= 1'b0;
    end else begin
      ivl_q  <= ivl_d;
      debt_q <= debt_d;
      lost_q <= lost_d;
    end
  end

  assign debt     = debt_q;
  assign ref_lost = lost_q;

endmodule

// File: rtl/dram_sched.sv
// GR8RAM DRAM access/refresh scheduler: shares each bus cycle's two DRAM slots
// between 6502 RAM-register accesses and CBR refresh; all strobes registered.
module dram_sched
  import gr8ram_pkg::*;
#(
  parameter int REF_INTERVAL = 13,
  parameter int DEBT_MAX     = 4,
  parameter int DEBT_W       = 3
) (
  input  logic              C7M,
  input  logic              nRES,
  input  logic [2:0]        S,
  input  logic              RAMSEL,
  input  logic              nWE,
  input  logic              BankSel,
  output logic              nRAS,
  output logic              nCAS0,
  output logic              nCAS1,
  output logic              ASel,
  output logic              RefActive,
  output logic [DEBT_W-1:0] Debt,
  output logic              RefLost
);

  // state      | meaning
  // IDLE       | no DRAM activity, all strobes off
  // REF_CAS    | CBR step 1: both CAS low
  // REF_CASRAS | CBR step 2: both CAS and RAS low
  // REF_RAS    | CBR step 3: RAS only
  // CPU_ROW    | row address on RA, RAS low
  // CPU_COL    | column address, RAS low, bank CAS if read
  // CPU_HOLD   | RAS and bank CAS low (late CAS for writes)

  state_e     state_q, state_d;
  logic [2:0] s_prev_q, s_prev_d;
  logic       we_n_q, we_n_d, bank_q, bank_d;
  logic       ras_n_q, ras_n_d, cas0_n_q, cas0_n_d, cas1_n_q, cas1_n_d;
  logic       asel_q, asel_d, ref_act_q, ref_act_d;
  logic       sync_edge, ref_start, cas_on;

  assign sync_edge = (S == PH_SYNC) && (s_prev_q != PH_SYNC);

  always_comb begin
    s_prev_d  = S;
    we_n_d    = we_n_q;
    bank_d    = bank_q;
    ref_start = 1'b0;
    case (state_q)
      REF_CAS:    state_d = REF_CASRAS;
      REF_CASRAS: state_d = REF_RAS;
      CPU_ROW:    state_d = CPU_COL;
      CPU_COL:    state_d = CPU_HOLD;
      default:    state_d = IDLE;
    endcase

    // A resync edge aborts any running sequence; the spent debt is not returned.
    if (S == 3'd0) begin
      state_d = IDLE;
    end else if (sync_edge) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
      end else if (Debt != '0) begin
        state_d   = REF_CAS;
        ref_start = 1'b1;
      end
    end else if (S == PH_DECIDE && state_d == IDLE) begin
      if (RAMSEL) begin
        state_d = CPU_ROW;
        we_n_d  = nWE;
        bank_d  = BankSel;
      end else if (Debt != '0) begin
        state_d   = REF_CAS;
        ref_start = 1'b1;
      end
    end

    ras_n_d   = 1'b1;
    cas0_n_d  = 1'b1;
    cas1_n_d  = 1'b1;
    asel_d    = 1'b0;
    ref_act_d = 1'b0;
    cas_on    = 1'b0;
    case (state_d)
      REF_CAS: begin
        cas0_n_d  = 1'b0;
        cas1_n_d  = 1'b0;
        ref_act_d = 1'b1;
      end
      REF_CASRAS: begin
        ras_n_d   = 1'b0;
        cas0_n_d  = 1'b0;
        cas1_n_d  = 1'b0;
        ref_act_d = 1'b1;
      end
      REF_RAS: begin
        ras_n_d   = 1'b0;
        ref_act_d = 1'b1;
      end
      CPU_ROW: begin
        ras_n_d = 1'b0;
        asel_d  = 1'b1;
      end
      CPU_COL: begin
        ras_n_d = 1'b0;
        cas_on  = we_n_d;
      end
      CPU_HOLD: begin
        ras_n_d = 1'b0;
        cas_on  = 1'b1;
      end
      default: ;
    endcase
    if (cas_on) begin
      if (bank_d) cas1_n_d = 1'b0;
      else        cas0_n_d = 1'b0;
    end
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state_q   <= IDLE;
      s_prev_q  <= 3'd0;
      we_n_q    <= 1'b1;
      bank_q    <= 1'b0;
      ras_n_q   <= 1'b1;
      cas0_n_q  <= 1'b1;
      cas1_n_q  <= 1'b1;
      asel_q    <= 1'b0;
      ref_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_prev_q  <= s_prev_d;
      we_n_q    <= we_n_d;
      bank_q    <= bank_d;
      ras_n_q   <= ras_n_d;
      cas0_n_q  <= cas0_n_d;
      cas1_n_q  <= cas1_n_d;
      asel_q    <= asel_d;
      ref_act_q <= ref_act_d;
    end
  end

  assign nRAS      = ras_n_q;
  assign nCAS0     = cas0_n_q;
  assign nCAS1     = cas1_n_q;
  assign ASel      = asel_q;
  assign RefActive = ref_act_q;

  ref_debt_ctr #(
    .REF_INTERVAL(REF_INTERVAL),
    .DEBT_MAX    (DEBT_MAX),
    .DEBT_W      (DEBT_W)
  ) u_debt (
    .clk_sys  (C7M),
    .rst_n    (nRES),
    .sync_edge(sync_edge),
    .ref_start(ref_start),
    .debt     (Debt),
    .ref_lost (RefLost)
  );

endmodule

// File: tb/tb_dram_sched.sv
// Bench for dram_sched: per-cycle comparison against a sequence-table model plus directed literal checks.
module tb_dram_sched;

  localparam int REF_INTERVAL = 13;
  localparam int DEBT_MAX     = 4;
  localparam int DEBT_W       = 3;

  logic              C7M = 1'b0;
  logic              nRES = 1'b0;
  logic [2:0]        S = 3'd0;
  logic              RAMSEL = 1'b0;
  logic              nWE = 1'b1;
  logic              BankSel = 1'b0;
  logic              nRAS, nCAS0, nCAS1, ASel, RefActive, RefLost;
  logic [DEBT_W-1:0] Debt;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  dram_sched #(
    .REF_INTERVAL(REF_INTERVAL),
    .DEBT_MAX    (DEBT_MAX),
    .DEBT_W      (DEBT_W)
  ) dut (
    .C7M      (C7M),
    .nRES     (nRES),
    .S        (S),
    .RAMSEL   (RAMSEL),
    .nWE      (nWE),
    .BankSel  (BankSel),
    .nRAS     (nRAS),
    .nCAS0    (nCAS0),
    .nCAS1    (nCAS1),
    .ASel     (ASel),
    .RefActive(RefActive),
    .Debt     (Debt),
    .RefLost  (RefLost)
  );

  always #5 C7M = ~C7M;

  // Model: a running sequence is (kind, age); kind 0 none, 1 refresh, 2 cpu.
  int         m_ivl = 0, m_debt = 0, m_kind = 0, m_age = 0;
  bit         m_lost = 1'b0, m_we_n = 1'b1, m_bank = 1'b0;
  logic [2:0] m_prev = 3'd0;
  bit         m_sync, m_credit, m_start, m_busy;

  always @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      m_ivl = 0; m_debt = 0; m_lost = 1'b0; m_kind = 0; m_age = 0; m_prev = 3'd0;
    end else begin
      m_sync = (S == 3'd1) && (m_prev != 3'd1);
      m_prev = S;
      m_busy = (m_kind != 0);
      m_credit = 1'b0;
      m_start = 1'b0;
      if (m_kind != 0) begin
        m_age++;
        if (m_age == 3) begin m_kind = 0; m_age = 0; end
      end
      if (m_sync) begin
        m_ivl++;
        if (m_ivl == REF_INTERVAL) begin m_ivl = 0; m_credit = 1'b1; end
      end
      if (S == 3'd0) begin
        m_kind = 0;
      end else if (m_sync) begin
        if (m_busy) m_kind = 0;
        else if (m_debt > 0) begin m_kind = 1; m_age = 0; m_start = 1'b1; end
      end else if (S == 3'd4 && m_kind == 0) begin
        if (RAMSEL) begin
          m_kind = 2; m_age = 0; m_we_n = nWE; m_bank = BankSel;
        end else if (m_debt > 0) begin
          m_kind = 1; m_age = 0; m_start = 1'b1;
        end
      end
      if (m_credit && !m_start) begin
        if (m_debt == DEBT_MAX) m_lost = 1'b1;
        else m_debt++;
      end else if (m_start && !m_credit) begin
        m_debt--;
      end
    end
  end

  function automatic logic [8:0] exp_vec();
    logic ras, c0, c1, as, ra, cas;
    logic [2:0] d;
    ras = 1'b1; c0 = 1'b1; c1 = 1'b1; as = 1'b0; ra = 1'b0; cas = 1'b0;
    if (m_kind == 1) begin
      ra  = 1'b1;
      ras = (m_age == 0);
      c0  = (m_age == 2);
      c1  = (m_age == 2);
    end else if (m_kind == 2) begin
      ras = 1'b0;
      as  = (m_age == 0);
      cas = (m_age == 2) || (m_age == 1 && m_we_n);
      c0  = !(cas && !m_bank);
      c1  = !(cas && m_bank);
    end
    d = 3'(m_debt);
    return {ras, c0, c1, as, ra, m_lost, d};
  endfunction

  logic [8:0] act_v, exp_v;

  always @(negedge C7M) begin
    if (cmp_on) begin
      act_v = {nRAS, nCAS0, nCAS1, ASel, RefActive, RefLost, Debt};
      exp_v = exp_vec();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model t=%0t S=%0d {nRAS,nCAS0,nCAS1,ASel,RefAct,RefLost,Debt} got %b expected %b",
                 $time, S, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] s, input logic r, input logic w, input logic b);
    S = s; RAMSEL = r; nWE = w; BankSel = b;
    @(posedge C7M);
    #1;
  endtask

  task automatic fcycle(input logic r, input logic w, input logic b);
    for (int i = 1; i <= 7; i++) step(3'(i), r, w, b);
  endtask

  // CPU access truncated at S5 so the next S1 resync aborts it (suppresses slot A).
  task automatic pcycle();
    step(3'd1, 1'b0, 1'b1, 1'b0);
    step(3'd2, 1'b0, 1'b1, 1'b0);
    step(3'd3, 1'b0, 1'b1, 1'b0);
    step(3'd4, 1'b1, 1'b1, 1'b0);
    step(3'd5, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    @(posedge C7M); #1;
    cmp_on = 1'b1;
    @(posedge C7M); #1;
    chk("reset_nRAS", nRAS, 1);
    chk("reset_ASel", ASel, 0);
    chk("reset_debt", Debt, 0);
    nRES = 1'b1;

    // read, bank 1
    for (int i = 1; i <= 7; i++) begin
      step(3'(i), 1'b1, 1'b1, 1'b1);
      if (i == 4) begin chk("rd_row_nRAS", nRAS, 0); chk("rd_row_ASel", ASel, 1); chk("rd_row_nCAS1", nCAS1, 1); end
      if (i == 5) begin chk("rd_col_ASel", ASel, 0); chk("rd_col_nCAS1", nCAS1, 0); chk("rd_col_nCAS0", nCAS0, 1); end
      if (i == 6) begin chk("rd_hold_nCAS1", nCAS1, 0); chk("rd_hold_nCAS0", nCAS0, 1); end
      if (i == 7) begin chk("rd_end_nRAS", nRAS, 1); chk("rd_end_nCAS1", nCAS1, 1); end
    end
    // write, bank 0: late CAS
    for (int i = 1; i <= 7; i++) begin
      step(3'(i), 1'b1, 1'b0, 1'b0);
      if (i == 5) begin chk("wr_col_nCAS0", nCAS0, 1); chk("wr_col_nRAS", nRAS, 0); end
      if (i == 6) begin chk("wr_hold_nCAS0", nCAS0, 0); chk("wr_hold_nCAS1", nCAS1, 1); end
    end
    // reset in the middle of CPU_COL
    for (int i = 1; i <= 5; i++) step(3'(i), 1'b1, 1'b1, 1'b0);
    chk("pre_reset_nCAS0", nCAS0, 0);
    #2 nRES = 1'b0;
    #1;
    chk("async_reset_nRAS", nRAS, 1);
    chk("async_reset_nCAS0", nCAS0, 1);
    chk("async_reset_nCAS1", nCAS1, 1);
    chk("async_reset_debt", Debt, 0);
    @(posedge C7M); #1;
    S = 3'd0;
    nRES = 1'b1;

    // first credit on the 13th resync after release
    for (int c = 1; c <= 12; c++) fcycle(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step(3'(i), 1'b1, 1'b1, 1'b0);
      if (i == 1) chk("first_credit_debt", Debt, 1);
    end
    for (int i = 1; i <= 7; i++) begin
      step(3'(i), 1'b0, 1'b1, 1'b0);
      if (i == 1) begin chk("refA_cas_ract", RefActive, 1); chk("refA_cas_nCAS0", nCAS0, 0); chk("refA_cas_nRAS", nRAS, 1); chk("refA_debt", Debt, 0); end
      if (i == 2) begin chk("refA_casras_nRAS", nRAS, 0); chk("refA_casras_nCAS1", nCAS1, 0); end
      if (i == 3) begin chk("refA_ras_nCAS0", nCAS0, 1); chk("refA_ras_nRAS", nRAS, 0); end
      if (i == 4) chk("refA_done_ract", RefActive, 0);
    end

    // accumulate debt under resync aborts, then repay in both slots
    for (int c = 15; c <= 51; c++) pcycle();
    for (int i = 1; i <= 7; i++) begin
      step(3'(i), 1'b1, 1'b1, 1'b0);
      if (i == 1) chk("debt_three", Debt, 3);
    end
    fcycle(1'b0, 1'b1, 1'b0);
    chk("repay_two_slots", Debt, 1);
    fcycle(1'b0, 1'b1, 1'b0);
    chk("repay_done", Debt, 0);

    // credit coinciding with slot-A start
    for (int c = 55; c <= 89; c++) pcycle();
    fcycle(1'b1, 1'b1, 1'b0);
    chk("debt_before_simul", Debt, 2);
    pcycle();
    chk("simul_debt", Debt, 2);

    // saturation and sticky loss flag
    for (int c = 92; c <= 116; c++) pcycle();
    step(3'd1, 1'b0, 1'b1, 1'b0);
    chk("sat_debt", Debt, 4);
    chk("sat_no_loss_yet", RefLost, 0);
    for (int i = 2; i <= 5; i++) step(3'(i), (i >= 4), 1'b1, 1'b0);
    for (int c = 118; c <= 129; c++) pcycle();
    step(3'd1, 1'b0, 1'b1, 1'b0);
    chk("lost_set", RefLost, 1);
    chk("lost_debt", Debt, 4);
    for (int i = 2; i <= 5; i++) step(3'(i), (i >= 4), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(3'd0, 1'b1, 1'b1, 1'b0);
    chk("s0_idle_nRAS", nRAS, 1);
    fcycle(1'b0, 1'b1, 1'b0);
    step(3'd7, 1'b0, 1'b1, 1'b0);
    step(3'd7, 1'b1, 1'b1, 1'b0);
    chk("hold7_idle_nRAS", nRAS, 1);
    fcycle(1'b0, 1'b1, 1'b0);
    chk("sat_repaid", Debt, 0);
    chk("lost_sticky", RefLost, 1);

    nRES = 1'b0;
    #1;
    chk("reset_clears_lost", RefLost, 0);
    @(posedge C7M); #1;
    nRES = 1'b1;
    fcycle(1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
